mdu_scheduler: RTL and testbench

MDU_SCHEDULER -- requirements
Module: mdu_scheduler

---
 rtl/mdu_scheduler.sv | 131 +++++++++++++
 tb/tb_mdu_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_scheduler.sv
// Multiply/divide unit scheduler: runs MULT/MULTU/DIV/DIVU for a fixed number of
// cycles, owns the HI/LO registers and raises the pipeline stall for md instructions.
module mdu_scheduler #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_ID,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall_md
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_sgn;
    logic        r_busy;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;
    logic [63:0] w_prod;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_div_b;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    function automatic logic [31:0] cond_neg(input logic neg, input logic [31:0] v);
        return neg ? (32'd0 - v) : v;
    endfunction

    // Sign/zero extension to 64 bits makes one truncated multiply serve both MULT and MULTU.
    assign w_ext_a = r_sgn ? {{32{r_a[31]}}, r_a} : {32'd0, r_a};
    assign w_ext_b = r_sgn ? {{32{r_b[31]}}, r_b} : {32'd0, r_b};
    assign w_prod  = w_ext_a * w_ext_b;

    // Signed division on magnitudes; the zero divisor is replaced so the datapath never goes X.
    assign w_mag_a = cond_neg(r_sgn & r_a[31], r_a);
    assign w_mag_b = cond_neg(r_sgn & r_b[31], r_b);
    assign w_div_b = (r_b == 32'd0) ? 32'd1 : w_mag_b;
    assign w_q_mag = w_mag_a / w_div_b;
    assign w_r_mag = w_mag_a % w_div_b;
    assign w_quot  = cond_neg(r_sgn & (r_a[31] ^ r_b[31]), w_q_mag);
    assign w_rem   = cond_neg(r_sgn & r_a[31], w_r_mag);

    // Issue, countdown and HI/LO write-back state machine.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_sgn   <= 1'b0;
            r_busy  <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            3'd0, 3'd1: begin
                                r_a     <= rs_val;
                                r_b     <= rt_val;
                                r_sgn   <= ~op[0];
                                r_cnt   <= 4'(MULT_CYCLES);
                                r_state <= S_MUL;
                                r_busy  <= 1'b1;
                            end
                            3'd2, 3'd3: begin
                                r_a     <= rs_val;
                                r_b     <= rt_val;
                                r_sgn   <= ~op[0];
                                r_cnt   <= 4'(DIV_CYCLES);
                                r_state <= S_DIV;
                                r_busy  <= 1'b1;
                            end
                            3'd4:    r_hi <= rs_val;
                            3'd5:    r_lo <= rs_val;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_hi    <= w_prod[63:32];
                        r_lo    <= w_prod[31:0];
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_DIV: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        if (r_b != 32'd0) begin
                            r_hi <= w_rem;
                            r_lo <= w_quot;
                        end
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign stall_md = md_ID & (r_busy | start);

endmodule

// File: tb/tb_mdu_scheduler.sv
// Randomised and directed bench for mdu_scheduler against a result-queue style reference model.
module tb_mdu_scheduler;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        md_ID;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall_md;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the result is computed at acceptance and applied when the wait expires.
    logic        m_busy = 1'b0;
    int          m_left = 0;
    logic        m_write = 1'b0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] m_nhi = 32'd0;
    logic [31:0] m_nlo = 32'd0;

    mdu_scheduler #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .md_ID(md_ID),
        .busy(busy), .hi(hi), .lo(lo), .stall_md(stall_md)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic s, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0;
                if (m_write) begin
                    m_hi = m_nhi;
                    m_lo = m_nlo;
                end
            end
        end else if (s) begin
            case (o)
                3'd0: begin
                    sp = sa * sb;
                    m_nhi = sp[63:32]; m_nlo = sp[31:0];
                    m_write = 1'b1; m_busy = 1'b1; m_left = MC;
                end
                3'd1: begin
                    up = ua * ub;
                    m_nhi = up[63:32]; m_nlo = up[31:0];
                    m_write = 1'b1; m_busy = 1'b1; m_left = MC;
                end
                3'd2: begin
                    m_write = (b != 32'd0);
                    if (b != 32'd0) begin
                        sp = sa / sb; m_nlo = sp[31:0];
                        sp = sa % sb; m_nhi = sp[31:0];
                    end
                    m_busy = 1'b1; m_left = DC;
                end
                3'd3: begin
                    m_write = (b != 32'd0);
                    if (b != 32'd0) begin
                        up = ua / ub; m_nlo = up[31:0];
                        up = ua % ub; m_nhi = up[31:0];
                    end
                    m_busy = 1'b1; m_left = DC;
                end
                3'd4: m_hi = a;
                3'd5: m_lo = a;
                default: ;
            endcase
        end
    endtask

    // One clock cycle: drive at the falling edge, check stall before and state after the rising edge.
    task automatic step(input logic s, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic md);
        start = s; op = o; rs_val = a; rt_val = b; md_ID = md;
        #1;
        check("stall_md", 32'(stall_md), 32'(md & (m_busy | s)));
        @(posedge clk);
        model_edge(s, o, a, b);
        #1;
        check("busy", 32'(busy), 32'(m_busy));
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic md);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, $urandom, $urandom, md);
    endtask

    // Asynchronous reset pulse raised mid-cycle with a start request that must be ignored.
    task automatic pulse_reset();
        start = 1'b1; op = 3'd0; md_ID = 1'b1; rs_val = 32'd9; rt_val = 32'd9;
        #2;
        reset = 1'b1;
        #1;
        m_busy = 1'b0; m_left = 0; m_write = 1'b0; m_hi = 32'd0; m_lo = 32'd0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_stall", 32'(stall_md), 32'd1);
        @(posedge clk);
        #1;
        check("rst_hold_busy", 32'(busy), 32'd0);
        check("rst_hold_hi", hi, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'd0; rs_val = 32'd0; rt_val = 32'd0; md_ID = 1'b0;
        #1;
        check("init_busy", 32'(busy), 32'd0);
        check("init_hi", hi, 32'd0);
        check("init_lo", lo, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // MULT / MULTU of -2 and 3
        step(1'b1, 3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
        idle(MC, 1'b0);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);
        step(1'b1, 3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        idle(MC, 1'b0);
        check("multu_hi", hi, 32'h0000_0002);
        check("multu_lo", lo, 32'hFFFF_FFFA);

        // DIV -7/2, then DIVU by zero leaves HI/LO alone
        step(1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        idle(DC, 1'b0);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        step(1'b1, 3'd3, 32'd7, 32'd0, 1'b0);
        idle(DC - 1, 1'b0);
        check("divz_busy_last", 32'(busy), 32'd1);
        idle(1, 1'b0);
        check("divz_hi", hi, 32'hFFFF_FFFF);
        check("divz_lo", lo, 32'hFFFF_FFFD);

        // MTHI then MTLO on consecutive edges
        step(1'b1, 3'd4, 32'h1234_5678, 32'd0, 1'b0);
        check("mthi", hi, 32'h1234_5678);
        step(1'b1, 3'd5, 32'h9ABC_DEF0, 32'd0, 1'b1);
        check("mtlo", lo, 32'h9ABC_DEF0);
        check("mt_busy", 32'(busy), 32'd0);

        // Stall window with and without md_ID
        step(1'b1, 3'd0, 32'd6, 32'd7, 1'b1);
        idle(MC, 1'b1);
        idle(2, 1'b1);
        step(1'b1, 3'd1, 32'd6, 32'd7, 1'b0);
        idle(MC, 1'b0);

        // Overflowing DIV with a MULT start at busy cycle 3 that must be ignored
        step(1'b1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle(2, 1'b0);
        step(1'b1, 3'd0, 32'd3, 32'd3, 1'b0);
        idle(DC - 3, 1'b0);
        check("divovf_lo", lo, 32'h8000_0000);
        check("divovf_hi", hi, 32'd0);
        check("divovf_busy", 32'(busy), 32'd0);

        // Reset at busy cycle 4 of MULT aborts it
        step(1'b1, 3'd4, 32'd1, 32'd0, 1'b0);
        step(1'b1, 3'd5, 32'd2, 32'd0, 1'b0);
        step(1'b1, 3'd0, 32'd100, 32'd100, 1'b0);
        idle(3, 1'b0);
        pulse_reset();
        idle(MC + 2, 1'b0);
        check("abort_hi", hi, 32'd0);
        step(1'b1, 3'd1, 32'd4, 32'd5, 1'b0);
        idle(MC, 1'b0);
        check("post_rst_lo", lo, 32'd20);

        // Randomised traffic, operand churn while busy, occasional reset
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset();
            end else begin
                step(1'($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)),
                     pick_val(), pick_val(), 1'($urandom_range(0, 1)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
